ps2_key_decoder: RTL

Receives PS/2 keyboard frames on the raw ps2_clk/ps2_data pins and decodes Set-2 scan codes, including the make, break (F0) and extended (E0) sequences. It produces the single-cycle key pulses consumed by the game state controller (spacebar_pressed, enter_pressed) and level "held" signals for paddle control (left/right arrows). It sits between the board PS/2 pins and the game logic, entirely in the clk domain.

---
 rtl/ps2_key_decoder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 Set-2 receiver and key decoder producing game key pulses and held levels.
module ps2_key_decoder #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       spacebar_pressed,
   output logic       enter_pressed,
   output logic       left_held,
   output logic       right_held,
   output logic [7:0] scan_code,
   output logic       scan_valid,
   output logic       frame_error
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
   logic [1:0] clk_sync, dat_sync;
   logic filt;
   logic [7:0] fcnt;
   logic fall;
   logic [3:0] bit_cnt;
   logic [8:0] sr;
   logic [TW-1:0] tcnt;
   state_t state, state_nx;
   logic mk, brk, ext;
   logic space_down, enter_down;
   logic is_29, is_5a, is_6b, is_74;
   // Synchronizers reset to the idle-high line level so reset never fakes an edge.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         clk_sync <= 2'b11;
         dat_sync <= 2'b11;
         filt     <= 1'b1;
         fcnt     <= '0;
      end else begin
         clk_sync <= {clk_sync[0], ps2_clk};
         dat_sync <= {dat_sync[0], ps2_data};
         if (clk_sync[1] == filt) fcnt <= '0;
         else if (fcnt == 8'(FILTER_LEN - 1)) begin
            filt <= clk_sync[1];
            fcnt <= '0;
         end else fcnt <= fcnt + 8'd1;
      end
   end
   assign fall = filt && !clk_sync[1] && (fcnt == 8'(FILTER_LEN - 1));
   // Bits 1..9 shift data and parity in LSB first; bit 10 is the stop bit.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         bit_cnt     <= '0;
         sr          <= '0;
         tcnt        <= '0;
         scan_code   <= 8'h00;
         scan_valid  <= 1'b0;
         frame_error <= 1'b0;
      end else begin
         scan_valid  <= 1'b0;
         frame_error <= 1'b0;
         if (fall) begin
            tcnt <= '0;
            if (bit_cnt == 4'd0) bit_cnt <= dat_sync[1] ? 4'd0 : 4'd1;
            else if (bit_cnt == 4'd10) begin
               bit_cnt <= '0;
               if (dat_sync[1] && ^sr) begin
                  scan_code  <= sr[7:0];
                  scan_valid <= 1'b1;
               end else frame_error <= 1'b1;
            end else begin
               sr      <= {dat_sync[1], sr[8:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end
         end else if (bit_cnt == 4'd0) tcnt <= '0;
         else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            tcnt        <= '0;
            bit_cnt     <= '0;
            frame_error <= 1'b1;
         end else tcnt <= tcnt + TW'(1);
      end
   end
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      mk       = 1'b0;
      brk      = 1'b0;
      ext      = 1'b0;
      if (scan_valid) begin
         case (state)
            IDLE: begin
               state_nx = (scan_code == 8'hE0) ? GOT_E0 : (scan_code == 8'hF0) ? GOT_F0 : IDLE;
               mk       = (scan_code != 8'hE0) && (scan_code != 8'hF0);
            end
            GOT_E0: begin
               state_nx = (scan_code == 8'hF0) ? GOT_E0F0 : (scan_code == 8'hE0) ? GOT_E0 : IDLE;
               mk       = (scan_code != 8'hE0) && (scan_code != 8'hF0);
               ext      = 1'b1;
            end
            GOT_F0: begin
               state_nx = IDLE;
               brk      = 1'b1;
            end
            default: begin
               state_nx = IDLE;
               brk      = 1'b1;
               ext      = 1'b1;
            end
         endcase
      end
   end
   assign is_29 = scan_code == 8'h29;
   assign is_5a = scan_code == 8'h5A;
   assign is_6b = scan_code == 8'h6B;
   assign is_74 = scan_code == 8'h74;
   always_ff @(posedge clk) begin
      if (!resetn) begin
         spacebar_pressed <= 1'b0;
         enter_pressed    <= 1'b0;
         space_down       <= 1'b0;
         enter_down       <= 1'b0;
         left_held        <= 1'b0;
         right_held       <= 1'b0;
      end else begin
         spacebar_pressed <= mk && !ext && is_29 && !space_down;
         enter_pressed    <= mk && !ext && is_5a && !enter_down;
         space_down       <= (mk && !ext && is_29) || (space_down && !(brk && !ext && is_29));
         enter_down       <= (mk && !ext && is_5a) || (enter_down && !(brk && !ext && is_5a));
         left_held        <= (mk && ext && is_6b) || (left_held && !(brk && ext && is_6b));
         right_held       <= (mk && ext && is_74) || (right_held && !(brk && ext && is_74));
      end
   end
endmodule
